// File: rtl/adder_sched.sv
// Round-robin front end that shares one pipelined adder among several requesters
// and routes each sum back to the requester that issued the operands.
module adder_sched #(
    parameter int bits    = 8,
    parameter int num     = 4,
    parameter int latency = 1,
    localparam int idw    = (num > 1) ? $clog2(num) : 1,
    localparam int cw     = $clog2(latency + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [num-1:0]        req_valid,
    input  logic [num*bits-1:0]   req_i0,
    input  logic [num*bits-1:0]   req_i1,
    output logic [num-1:0]        req_ready,
    input  logic [num-1:0]        req_mask,
    output logic                  add_valid,
    output logic [bits-1:0]       add_i0,
    output logic [bits-1:0]       add_i1,
    input  logic [bits-1:0]       add_o,
    input  logic                  add_valid_out,
    output logic [num-1:0]        rsp_valid,
    output logic [bits-1:0]       rsp_data,
    output logic [idw-1:0]        rsp_id,
    output logic [cw-1:0]         inflight,
    output logic                  err
);

    // Handshake: requester k transfers in a cycle where req_valid[k] & req_ready[k];
    // req_ready is a pure function of req_valid, req_mask and the rotating pointer.

    logic [num-1:0] eligible;
    logic           grant_found;
    logic [idw-1:0] grant_id;
    logic [idw-1:0] ptr;
    logic [idw:0]   cand;
    logic [idw-1:0] issue_id;
    logic [latency-1:0] pipe_v;
    logic [idw-1:0] pipe_id [latency];
    logic           tail_v;
    logic [idw-1:0] tail_id;
    logic           rsp_tracked;
    logic           infl_inc;
    logic           infl_dec;

    assign eligible = req_valid & req_mask;

    // Search ptr, ptr+1, ... with wrap; first eligible index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < num; i++) begin
            cand = {1'b0, ptr} + (idw+1)'(i);
            if (cand >= (idw+1)'(num)) cand = cand - (idw+1)'(num);
            if (!grant_found && eligible[cand[idw-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[idw-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            add_valid <= 1'b0;
            add_i0    <= '0;
            add_i1    <= '0;
            issue_id  <= '0;
        end else begin
            add_valid <= grant_found;
            if (grant_found) begin
                add_i0   <= req_i0[grant_id*bits +: bits];
                add_i1   <= req_i1[grant_id*bits +: bits];
                issue_id <= grant_id;
                ptr      <= (grant_id == idw'(num - 1)) ? '0 : grant_id + idw'(1);
            end
        end
    end

    // Id pipeline runs in lockstep with the adder so its tail lines up with add_valid_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < latency; i++) pipe_id[i] <= '0;
        end else begin
            pipe_v[0]  <= add_valid;
            pipe_id[0] <= issue_id;
            for (int i = 1; i < latency; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    assign tail_v  = pipe_v[latency-1];
    assign tail_id = pipe_id[latency-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_id      <= '0;
            rsp_tracked <= 1'b0;
            err         <= 1'b0;
        end else begin
            rsp_valid   <= '0;
            rsp_tracked <= 1'b0;
            if (add_valid_out) begin
                rsp_valid   <= num'(1) << tail_id;
                rsp_data    <= add_o;
                rsp_id      <= tail_id;
                rsp_tracked <= tail_v;
                if (!tail_v) err <= 1'b1;
            end
        end
    end

    // Untracked (orphan) responses never decrement, so the count cannot underflow.
    assign infl_inc = grant_found;
    assign infl_dec = rsp_tracked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (infl_inc && !infl_dec) begin
            inflight <= inflight + cw'(1);
        end else if (infl_dec && !infl_inc) begin
            inflight <= inflight - cw'(1);
        end
    end

endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: a 4-requester/latency-1 instance and a 1-requester/latency-3
// instance, each fed by a behavioural adder and checked against a queue-based model.
module tb_adder_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: num=4, latency=1 ----------------
    logic        rst_a = 1'b0;
    logic [3:0]  req_valid_a = '0, req_mask_a = '0, req_ready_a;
    logic [31:0] req_i0_a = '0, req_i1_a = '0;
    logic        add_valid_a;
    logic [7:0]  add_i0_a, add_i1_a;
    logic [7:0]  add_o_a = '0;
    logic        add_vo_a = 1'b0;
    logic [3:0]  rsp_valid_a;
    logic [7:0]  rsp_data_a;
    logic [1:0]  rsp_id_a;
    logic [1:0]  inflight_a;
    logic        err_a;

    adder_sched #(.bits(8), .num(4), .latency(1)) dut_a (
        .clk(clk), .rst_n(rst_a),
        .req_valid(req_valid_a), .req_i0(req_i0_a), .req_i1(req_i1_a),
        .req_ready(req_ready_a), .req_mask(req_mask_a),
        .add_valid(add_valid_a), .add_i0(add_i0_a), .add_i1(add_i1_a),
        .add_o(add_o_a), .add_valid_out(add_vo_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_id(rsp_id_a),
        .inflight(inflight_a), .err(err_a)
    );

    always @(posedge clk) begin
        add_vo_a <= add_valid_a;
        add_o_a  <= add_i0_a + add_i1_a;
    end

    // ---------------- instance B: num=1, latency=3 ----------------
    logic        rst_b = 1'b0;
    logic [0:0]  req_valid_b = '0, req_mask_b = 1'b1, req_ready_b;
    logic [7:0]  req_i0_b = '0, req_i1_b = '0;
    logic        add_valid_b;
    logic [7:0]  add_i0_b, add_i1_b;
    logic [7:0]  add_o_b;
    logic        add_vo_b;
    logic [0:0]  rsp_valid_b;
    logic [7:0]  rsp_data_b;
    logic [0:0]  rsp_id_b;
    logic [2:0]  inflight_b;
    logic        err_b;

    adder_sched #(.bits(8), .num(1), .latency(3)) dut_b (
        .clk(clk), .rst_n(rst_b),
        .req_valid(req_valid_b), .req_i0(req_i0_b), .req_i1(req_i1_b),
        .req_ready(req_ready_b), .req_mask(req_mask_b),
        .add_valid(add_valid_b), .add_i0(add_i0_b), .add_i1(add_i1_b),
        .add_o(add_o_b), .add_valid_out(add_vo_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_id(rsp_id_b),
        .inflight(inflight_b), .err(err_b)
    );

    // The adder is not reset, so results already inside it still emerge after a DUT reset.
    logic [2:0] vb_pipe = '0;
    logic [7:0] sb_pipe [3] = '{8'h0, 8'h0, 8'h0};
    always @(posedge clk) begin
        vb_pipe    <= {vb_pipe[1:0], add_valid_b};
        sb_pipe[0] <= add_i0_b + add_i1_b;
        sb_pipe[1] <= sb_pipe[0];
        sb_pipe[2] <= sb_pipe[1];
    end
    assign add_vo_b = vb_pipe[2];
    assign add_o_b  = sb_pipe[2];

    // ---------------- reference model state ----------------
    // Queue entry: {tracked, due_cycle[31:0], id[3:0], sum[7:0]}
    logic [44:0] exp_a_q[$];
    logic [44:0] exp_b_q[$];
    int          ptr_a = 0;
    int          infl_a = 0, infl_b = 0;
    logic        iss_v_a = 1'b0, iss_v_b = 1'b0;
    logic [7:0]  iss_i0_a = '0, iss_i1_a = '0, iss_i0_b = '0, iss_i1_b = '0;
    logic        err_exp_b = 1'b0;
    int          peak_b = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_sum(input logic [7:0] x, input logic [7:0] y);
        return 8'((int'(x) + int'(y)) % 256);
    endfunction

    // Called at posedge+1; drives inputs, checks at mid-cycle, updates model, returns at next posedge+1.
    task automatic cycle_a(input logic [3:0] v, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] b);
        int          g;
        int          idx;
        logic [44:0] e;
        logic [3:0]  exp_rv;
        logic        popped_tracked;
        req_valid_a = v; req_mask_a = m; req_i0_a = a; req_i1_a = b;
        #4;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            idx = (ptr_a + i) % 4;
            if (g < 0 && v[idx] && m[idx]) g = idx;
        end
        chk("a_ready", req_ready_a, (g < 0) ? 64'd0 : (64'd1 << g));
        chk("a_add_valid", add_valid_a, iss_v_a);
        if (iss_v_a) begin
            chk("a_add_i0", add_i0_a, iss_i0_a);
            chk("a_add_i1", add_i1_a, iss_i1_a);
        end
        exp_rv = '0;
        popped_tracked = 1'b0;
        if (exp_a_q.size() > 0 && exp_a_q[0][43:12] == 32'(cyc)) begin
            e = exp_a_q.pop_front();
            exp_rv = 4'(1 << e[11:8]);
            popped_tracked = e[44];
            chk("a_rsp_data", rsp_data_a, e[7:0]);
            chk("a_rsp_id", rsp_id_a, e[11:8]);
        end
        chk("a_rsp_valid", rsp_valid_a, exp_rv);
        chk("a_inflight", inflight_a, infl_a);
        chk("a_err", err_a, 0);
        if (popped_tracked) infl_a--;
        iss_v_a = (g >= 0);
        if (g >= 0) begin
            infl_a++;
            iss_i0_a = a[g*8 +: 8];
            iss_i1_a = b[g*8 +: 8];
            exp_a_q.push_back({1'b1, 32'(cyc + 3), 4'(g), ref_sum(a[g*8 +: 8], b[g*8 +: 8])});
            ptr_a = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_b(input logic v, input logic [7:0] a, input logic [7:0] b);
        logic [44:0] e;
        logic        exp_rv;
        logic        popped_tracked;
        req_valid_b = v; req_i0_b = a; req_i1_b = b;
        #4;
        chk("b_ready", req_ready_b, v);
        chk("b_add_valid", add_valid_b, iss_v_b);
        if (iss_v_b) begin
            chk("b_add_i0", add_i0_b, iss_i0_b);
            chk("b_add_i1", add_i1_b, iss_i1_b);
        end
        exp_rv = 1'b0;
        popped_tracked = 1'b0;
        if (exp_b_q.size() > 0 && exp_b_q[0][43:12] == 32'(cyc)) begin
            e = exp_b_q.pop_front();
            exp_rv = 1'b1;
            popped_tracked = e[44];
            if (!e[44]) err_exp_b = 1'b1;
            chk("b_rsp_data", rsp_data_b, e[7:0]);
            chk("b_rsp_id", rsp_id_b, 0);
        end
        chk("b_rsp_valid", rsp_valid_b, exp_rv);
        chk("b_inflight", inflight_b, infl_b);
        chk("b_err", err_b, err_exp_b);
        if (int'(inflight_b) > peak_b) peak_b = int'(inflight_b);
        if (popped_tracked) infl_b--;
        iss_v_b = v;
        if (v) begin
            infl_b++;
            iss_i0_b = a;
            iss_i1_b = b;
            exp_b_q.push_back({1'b1, 32'(cyc + 5), 4'd0, ref_sum(a, b)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_add_valid"}, add_valid_a, 0);
        chk({tag, "_add_i0"}, add_i0_a, 0);
        chk({tag, "_add_i1"}, add_i1_a, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_a, 0);
        chk({tag, "_rsp_data"}, rsp_data_a, 0);
        chk({tag, "_rsp_id"}, rsp_id_a, 0);
        chk({tag, "_inflight"}, inflight_a, 0);
        chk({tag, "_err"}, err_a, 0);
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, "_add_valid"}, add_valid_b, 0);
        chk({tag, "_add_i0"}, add_i0_b, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_b, 0);
        chk({tag, "_rsp_data"}, rsp_data_b, 0);
        chk({tag, "_inflight"}, inflight_b, 0);
        chk({tag, "_err"}, err_b, 0);
    endtask

    initial begin
        logic [44:0] held;
        int          t0;
        logic [3:0]  m;

        // Clock/reset
        @(posedge clk);
        #1;
        chk_reset_a("a_rst");
        chk_reset_b("b_rst");
        chk("a_rst_ready", req_ready_a, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 2: 0x12 + 0x34
        cycle_a(4'b0100, 4'hF, 32'h0012_0000, 32'h0034_0000);
        repeat (4) cycle_a(4'h0, 4'hF, '0, '0);

        // Reset again so the pointer starts at 0, then full round robin
        rst_a = 1'b0;
        #1;
        chk_reset_a("a_rst2");
        #3;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        ptr_a = 0; infl_a = 0; iss_v_a = 1'b0; exp_a_q.delete();
        repeat (8) cycle_a(4'hF, 4'hF, $urandom, $urandom);
        repeat (4) cycle_a(4'h0, 4'hF, '0, '0);

        // Wrap-around sum
        cycle_a(4'b0001, 4'hF, 32'h0000_00FF, 32'h0000_0002);
        repeat (3) cycle_a(4'h0, 4'hF, '0, '0);

        // Move pointer to 2, then mask out requester 2
        cycle_a(4'b0010, 4'hF, $urandom, $urandom);
        repeat (4) cycle_a(4'hF, 4'b1011, $urandom, $urandom);
        repeat (4) cycle_a(4'h0, 4'hF, '0, '0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            cycle_a(4'($urandom_range(0, 15)), m, $urandom, $urandom);
        end
        repeat (5) cycle_a(4'h0, 4'hF, '0, '0);
        chk("a_drain", exp_a_q.size(), 0);

        // Instance B: five back-to-back transfers through a 3-cycle adder
        for (int n = 0; n < 5; n++) cycle_b(1'b1, 8'($urandom), 8'($urandom));
        repeat (8) cycle_b(1'b0, '0, '0);
        chk("b_peak", peak_b, 5);
        chk("b_drain", exp_b_q.size(), 0);

        // Reset one cycle after add_valid; the late adder result must raise err
        t0 = cyc;
        cycle_b(1'b1, 8'hA5, 8'h3C);
        held = exp_b_q[exp_b_q.size() - 1];
        cycle_b(1'b0, '0, '0);
        rst_b = 1'b0;
        #1;
        chk_reset_b("b_midrst");
        chk("b_midrst_ready", req_ready_b, 0);
        #3;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        exp_b_q.delete();
        exp_b_q.push_back({1'b0, 32'(t0 + 5), 4'd0, held[7:0]});
        infl_b = 0; iss_v_b = 1'b0; err_exp_b = 1'b0;
        repeat (5) cycle_b(1'b0, '0, '0);
        chk("b_err_sticky", err_b, 1);
        chk("b_orphan_drain", exp_b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_sched.md
# adder_sched

Round-robin scheduler that shares one pipelined 2-input adder (bits-wide, fixed latency) among `num` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues one pair per cycle to the adder. It tracks the requester id of every in-flight operation and routes each sum back to the requester that issued it. It sits in front of a single `adder` instance (num=2) so several producers can use it without duplicating adder hardware.

## Interface
- `bits`, 8, operand/result width
- `num`, 4, number of requesters (1..16)
- `latency`, 1, adder cycles from `add_valid` to `add_valid_out` (≥1)
- `idw` = max(1, $clog2(num)), derived, requester-id width

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in num: per-requester request valid
- `req_i0` in num*bits: packed operand A, requester k at [k*bits +: bits]
- `req_i1` in num*bits: packed operand B, same packing
- `req_ready` out num: one-hot grant; a transfer occurs when req_valid[k] & req_ready[k]
- `req_mask` in num: 1 = requester k eligible for grant
- `add_valid` out 1: operand pair valid to adder
- `add_i0`, `add_i1` out bits: operands to adder
- `add_o` in bits: adder result
- `add_valid_out` in 1: adder result valid
- `rsp_valid` out num: one-hot result strobe to owning requester
- `rsp_data` out bits: result, shared by all requesters
- `rsp_id` out idw: owning requester index
- `inflight` out idw+... ($clog2(latency+3)): accepted but not yet responded count
- `err` out 1: sticky; `add_valid_out` seen with no tracked operation

## Operation
- Arbitration (combinational): eligible[k] = req_valid[k] & req_mask[k]. Grant the first eligible index searching ptr, ptr+1, … wrapping mod num. At most one `req_ready` bit high. `req_ready` is all-zero when nothing is eligible. `req_ready` never depends on adder state, because the adder has no backpressure.
- Pointer: on a transfer by k, ptr <= (k+1) mod num. Unchanged when there is no transfer. With num=1, ptr stays 0.
- Issue stage (registered): on a transfer, next cycle add_valid=1 and add_i0/add_i1 = granted operands. Issue id is pushed into an id pipeline `latency` stages deep, aligned with the adder. Otherwise add_valid=0 and add_i0/add_i1 hold their last values.
- Response stage (registered): when add_valid_out=1, next cycle rsp_valid[id]=1, rsp_data=add_o, rsp_id=id, where id is the tail of the id pipeline. Otherwise rsp_valid=0 and rsp_data/rsp_id hold.
- Arithmetic: performed by the adder; the result is mod 2^bits, and this block passes it through unchanged.
- inflight: +1 on transfer, −1 on rsp_valid pulse, net 0 when both occur in the same cycle. Maximum value is latency+2.
- err: set when add_valid_out=1 and the id-pipeline tail slot is not valid. Cleared only by reset. The response is still emitted, with rsp_id = tail id.
- Masking a requester mid-stream does not affect its in-flight operations; their responses are still delivered.

## Timing
- Reset (async assert, sync release) values:
  - req_ready combinational from inputs
  - add_valid=0, add_i0=0, add_i1=0
  - rsp_valid=0, rsp_data=0, rsp_id=0
  - inflight=0, err=0, ptr=0
  - id pipeline valid bits all 0
- Reset mid-operation drops all in-flight ids; late adder results after reset release set err.
- Latency: transfer at cycle T → add_valid at T+1 → add_valid_out at T+1+latency → rsp_valid at T+2+latency.
- Throughput: one transfer per cycle sustained; responses return in accept order.
- Fairness: any continuously eligible requester is granted within num cycles.

## Test plan
- Single request: num=4, latency=1. Requester 2 sends i0=0x12, i1=0x34 at T → req_ready=4'b0100 at T, add_valid at T+1, rsp_valid=4'b0100 with rsp_data=0x46 and rsp_id=2 at T+3, inflight 1→0.
- Round-robin: all four req_valid held high for 8 cycles with ptr=0 → grants 0,1,2,3,0,1,2,3. Each response is routed to the correct id, back-to-back, with rsp_data=i0+i1 per requester.
- Wrap-around sum: i0=0xFF, i1=0x02 → rsp_data=0x01.
- Mask and skip: req_mask=4'b1011 with all four valid, ptr=2 → grant order 3,0,1,3; requester 2 is never granted.
- Reset mid-flight: assert rst_n low one cycle after add_valid → all outputs return to reset values immediately. The adder's subsequent add_valid_out sets err=1 after release.
- latency=3, num=1: 5 consecutive transfers → responses on 5 consecutive cycles starting at T+5. inflight peaks at 5 and then drains to 0.
